// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite slave-side bus bundle for the SRAM slave
interface ahb_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte-lane writes, programmable wait states and two-cycle ERROR responses
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_sram_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int MEMW  = IDXW + OFFW;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic                  ready, valid, write;
  logic [1:0]            resp;
  logic [2:0]            size;
  logic [IDXW-1:0]       idx;
  logic [OFFW-1:0]       off;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BYTES-1:0]      be;
  logic [ADDR_WIDTH-1:0] mask;
  logic                  accept, bad, wr_en;
  logic                  unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HPROT};
  assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign mask   = (ONE << bus.HSIZE) - ONE;
  assign bad    = bus.HSIZE > 3'(OFFW) || (bus.HADDR & mask) != '0 || (bus.HADDR >> MEMW) != '0;
  // Only the zero-wait IDLE data phase retires a write; reset suppresses it.
  assign wr_en  = HRESETn && state == IDLE && valid && write;
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) be[b] = ((OFFW'(b) ^ off) >> size) == '0;
  end
  always_ff @(posedge HCLK)
    if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      resp  <= 2'b00;
      valid <= 1'b0;
      write <= 1'b0;
      size  <= '0;
      idx   <= '0;
      off   <= '0;
    end else if (ready) begin
      if (accept) begin
        idx   <= bus.HADDR[MEMW-1:OFFW];
        off   <= bus.HADDR[OFFW-1:0];
        size  <= bus.HSIZE;
        write <= bus.HWRITE;
        valid <= !bad;
        state <= bad ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE);
        ready <= !bad && WAIT_STATES == 0;
        resp  <= bad ? 2'b01 : 2'b00;
        cnt   <= bad ? 4'd0 : 4'(WAIT_STATES);
      end else begin
        valid <= 1'b0;
        state <= IDLE;
        ready <= 1'b1;
        resp  <= 2'b00;
      end
    end else if (state == ERR1) begin
      state <= ERR2;
      ready <= 1'b1;
    end else begin
      cnt   <= cnt - 4'd1;
      state <= cnt == 4'd1 ? IDLE : WAIT;
      ready <= cnt == 4'd1;
    end
  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = (ready && valid && !write) ? mem[idx] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: three SRAM slaves (0, 2, 3 wait states) on one AHB-Lite bus, scoreboard-checked against a word-array model
module tb_ahb_sram_slave;
  typedef struct {
    bit          err;
    bit          known;
    logic [31:0] rdata;
    int          waits;
  } exp_t;
  logic        clk, rst_n;
  logic        hsel, hwrite;
  logic [1:0]  asel, dsel, htrans, hresp;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hready, dp;
  int          checks = 0, errors = 0, lowcnt = 0;
  logic [1:0]  lowresp = 0;
  int          ws [3] = '{0, 2, 3};
  logic [31:0] mdl [int];
  exp_t        q [$];
  exp_t        me;
  ahb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  ahb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
  ahb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b2 ();
  ahb_sram_slave #(.WAIT_STATES(0)) u0 (.HCLK(clk), .HRESETn(rst_n), .bus(b0));
  ahb_sram_slave #(.WAIT_STATES(2)) u1 (.HCLK(clk), .HRESETn(rst_n), .bus(b1));
  ahb_sram_slave #(.WAIT_STATES(3)) u2 (.HCLK(clk), .HRESETn(rst_n), .bus(b2));
  assign {b0.HSEL, b0.HADDR, b0.HTRANS, b0.HWRITE, b0.HSIZE, b0.HBURST, b0.HPROT, b0.HWDATA, b0.HREADY} =
         {hsel && asel == 2'd0, haddr, htrans, hwrite, hsize, 3'b0, 4'b0, hwdata, hready};
  assign {b1.HSEL, b1.HADDR, b1.HTRANS, b1.HWRITE, b1.HSIZE, b1.HBURST, b1.HPROT, b1.HWDATA, b1.HREADY} =
         {hsel && asel == 2'd1, haddr, htrans, hwrite, hsize, 3'b0, 4'b0, hwdata, hready};
  assign {b2.HSEL, b2.HADDR, b2.HTRANS, b2.HWRITE, b2.HSIZE, b2.HBURST, b2.HPROT, b2.HWDATA, b2.HREADY} =
         {hsel && asel == 2'd2, haddr, htrans, hwrite, hsize, 3'b0, 4'b0, hwdata, hready};
  assign hready = dsel == 2'd0 ? b0.HREADYOUT : dsel == 2'd1 ? b1.HREADYOUT : b2.HREADYOUT;
  assign hresp  = dsel == 2'd0 ? b0.HRESP     : dsel == 2'd1 ? b1.HRESP     : b2.HRESP;
  assign hrdata = dsel == 2'd0 ? b0.HRDATA    : dsel == 2'd1 ? b1.HRDATA    : b2.HRDATA;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  // Data-phase decoder: which slave owns the current data phase.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dp   <= 1'b0;
      dsel <= 2'd0;
    end else if (hready) begin
      dp   <= hsel && htrans[1];
      dsel <= asel;
    end
  always @(negedge clk) begin
    if (!rst_n) begin
      lowcnt  = 0;
      lowresp = 0;
    end else if (dp) begin
      if (!hready) begin
        lowcnt++;
        lowresp = hresp;
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got resp %h, required no transfer", hresp);
      end else begin
        me = q.pop_front();
        chk("resp", 32'(hresp), me.err ? 32'd1 : 32'd0);
        chk("waits", 32'(lowcnt), 32'(me.waits));
        chk("low_resp", 32'(lowresp), me.err ? 32'd1 : 32'd0);
        if (me.known) chk("rdata", hrdata, me.rdata);
        lowcnt  = 0;
        lowresp = 0;
      end
    end
  end
  task automatic issue(input int s, input bit w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input bit track = 1'b1);
    exp_t        e;
    int          key, n;
    logic [31:0] word;
    e.err   = sz > 3'd2 || (a % (32'd1 << sz)) != 0 || a >= 32'h1000;
    e.waits = e.err ? 1 : ws[s];
    e.known = 1'b1;
    e.rdata = '0;
    key     = s * 1024 + int'(a[11:2]);
    if (!w && !e.err) begin
      e.known = mdl.exists(key);
      if (e.known) e.rdata = mdl[key];
    end
    if (w && !e.err && track) begin
      if (sz == 3'd2) mdl[key] = d;
      else if (mdl.exists(key)) begin
        word = mdl[key];
        for (int k = 0; k < (1 << sz); k++) word[(int'(a[1:0]) + k)*8 +: 8] = d[(int'(a[1:0]) + k)*8 +: 8];
        mdl[key] = word;
      end
    end
    if (track) q.push_back(e);
    asel   = 2'(s);
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    n = 0;
    forever begin
      @(negedge clk);
      if (hready) break;
      if (++n > 50) begin
        $display("FAIL accept_timeout: got HREADY low for %0d cycles, required under 50", n);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    hwdata = d;
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0) begin
      @(posedge clk);
      #1;
      if (++n > 100) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending responses, required 0", q.size());
        q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end
  initial begin
    int s, word, off, sz;
    bit oob, mis;
    rst_n = 0; hsel = 0; hwrite = 0; asel = 0; htrans = 0; hsize = 0; haddr = 0; hwdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(b0.HREADYOUT), 32'd1);
    chk("rst_ready1", 32'(b1.HREADYOUT), 32'd1);
    chk("rst_ready2", 32'(b2.HREADYOUT), 32'd1);
    chk("rst_resp0", 32'(b0.HRESP), 32'd0);
    chk("rst_resp1", 32'(b1.HRESP), 32'd0);
    chk("rst_resp2", 32'(b2.HRESP), 32'd0);
    chk("rst_rdata0", b0.HRDATA, 32'd0);
    chk("rst_rdata1", b1.HRDATA, 32'd0);
    chk("rst_rdata2", b2.HRDATA, 32'd0);
    rst_n = 1;
    @(posedge clk);
    #1;
    issue(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(0, 0, 32'h10, 3'd2, 32'h0);
    issue(1, 1, 32'h20, 3'd2, 32'hCAFE0020);
    issue(1, 0, 32'h20, 3'd2, 32'h0);
    issue(0, 1, 32'h0, 3'd2, 32'h12345678);
    issue(0, 1, 32'h1000, 3'd2, 32'hBAD0BAD0);
    issue(0, 0, 32'h1000, 3'd2, 32'h0);
    issue(0, 0, 32'h0, 3'd2, 32'h0);
    issue(0, 1, 32'h10, 3'd2, 32'h0);
    issue(0, 1, 32'h13, 3'd0, 32'hA55A5A5A);
    issue(0, 0, 32'h10, 3'd2, 32'h0);
    issue(0, 1, 32'h11, 3'd1, 32'hFFFFFFFF);
    issue(0, 0, 32'h10, 3'd2, 32'h0);
    issue(0, 1, 32'h40, 3'd2, 32'h1);
    issue(0, 0, 32'h40, 3'd2, 32'h0);
    issue(0, 1, 32'h44, 3'd3, 32'h0);
    drain();
    issue(2, 1, 32'h50, 3'd2, 32'h0DD0_0050);
    drain();
    issue(2, 1, 32'h50, 3'd2, 32'hEEEE_EEEE, 1'b0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_ready", 32'(b2.HREADYOUT), 32'd1);
    chk("mid_rst_resp", 32'(b2.HRESP), 32'd0);
    chk("mid_rst_rdata", b2.HRDATA, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    issue(2, 0, 32'h50, 3'd2, 32'h0);
    drain();
    for (int i = 0; i < 48; i++) issue(i / 16, 1, 32'h100 + 32'(i % 16) * 4, 3'd2, $urandom());
    for (int i = 0; i < 150; i++) begin
      s    = $urandom_range(0, 2);
      word = $urandom_range(0, 15);
      sz   = $urandom_range(0, 3);
      oob  = $urandom_range(0, 9) == 0;
      mis  = $urandom_range(0, 7) == 0;
      off  = mis ? $urandom_range(0, 3) : ($urandom_range(0, 3) & ~((1 << sz) - 1));
      issue(s, 1'($urandom_range(0, 1)), 32'h100 + 32'(word * 4 + off) + (oob ? 32'h1000 : 32'h0),
            3'(sz), $urandom());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
